// File: rtl/hazard_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pipe
//
// Carries each decoded instruction's register numbers and write/load controls
// from D through E, M and W. These are the inputs the hazard unit uses to
// detect hazards and select forwarding. The hazard unit's flushE squashes the
// D->E register. Three saturating counters record stall cycles, branch-squash
// bubbles and retired instructions for performance debug.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   rsD, rtD, writeregD         source/destination registers of the D instr
//   regwriteD, memtoregD        register-write enable / load flag in D
//   validD                      D holds a real instruction
//   stallD, flushE              hazard-unit stall of D / bubble into E
//   cnt_clr                     synchronous clear of the three counters
//   rsE, rtE                    source registers in E
//   writeregE/M/W               destination register per stage
//   regwriteE/M/W               register-write enable per stage
//   memtoregE/M                 load flag per stage
//   validW                      W holds a real instruction
//   stall_cnt, flush_cnt,
//   retire_cnt                  saturating performance counters (CNT_W bits)
// ---------------------------------------------------------------------------
module hazard_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       writeregD,
  input  logic             regwriteD,
  input  logic             memtoregD,
  input  logic             validD,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             cnt_clr,
  output logic [4:0]       rsE,
  output logic [4:0]       rtE,
  output logic [4:0]       writeregE,
  output logic [4:0]       writeregM,
  output logic [4:0]       writeregW,
  output logic             regwriteE,
  output logic             regwriteM,
  output logic             regwriteW,
  output logic             memtoregE,
  output logic             memtoregM,
  output logic             validW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    if (en && (cnt != CNT_MAX)) begin
      return cnt + CNT_ONE;
    end
    return cnt;
  endfunction

  logic validE;
  logic validM;
  logic bubble;
  logic regwrite_gated;

  // A flushed slot or an empty D both become a bubble. Register $0 is never a
  // forwarding source, so a write to it is dropped here.
  assign bubble         = flushE | ~validD;
  assign regwrite_gated = regwriteD & (writeregD != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rsE        <= '0;
      rtE        <= '0;
      writeregE  <= '0;
      regwriteE  <= 1'b0;
      memtoregE  <= 1'b0;
      validE     <= 1'b0;
      writeregM  <= '0;
      regwriteM  <= 1'b0;
      memtoregM  <= 1'b0;
      validM     <= 1'b0;
      writeregW  <= '0;
      regwriteW  <= 1'b0;
      validW     <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      // D -> E: loads every cycle; stallD does not hold E.
      if (bubble) begin
        rsE       <= '0;
        rtE       <= '0;
        writeregE <= '0;
        regwriteE <= 1'b0;
        memtoregE <= 1'b0;
        validE    <= 1'b0;
      end else begin
        rsE       <= rsD;
        rtE       <= rtD;
        writeregE <= writeregD;
        regwriteE <= regwrite_gated;
        memtoregE <= memtoregD;
        validE    <= 1'b1;
      end

      // E -> M
      writeregM <= writeregE;
      regwriteM <= regwriteE;
      memtoregM <= memtoregE;
      validM    <= validE;

      // M -> W
      writeregW <= writeregM;
      regwriteW <= regwriteM;
      validW    <= validM;

      // Counters: clear beats a same-cycle increment. Flushes during a stall
      // are load-use bubbles and are already counted as stall cycles.
      if (cnt_clr) begin
        stall_cnt  <= '0;
        flush_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        stall_cnt  <= sat_inc(stall_cnt, stallD);
        flush_cnt  <= sat_inc(flush_cnt, flushE & ~stallD);
        retire_cnt <= sat_inc(retire_cnt, validW);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
module tb_hazard_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, writeregD;
  logic        regwriteD, memtoregD, validD, stallD, flushE, cnt_clr;

  logic [4:0]  rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, validW;
  logic [15:0] stall_cnt, flush_cnt, retire_cnt;

  logic [4:0]  rsE2, rtE2, writeregE2, writeregM2, writeregW2;
  logic        regwriteE2, regwriteM2, regwriteW2, memtoregE2, memtoregM2, validW2;
  logic [1:0]  stall_cnt2, flush_cnt2, retire_cnt2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_pipe #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .validD(validD),
    .stallD(stallD), .flushE(flushE), .cnt_clr(cnt_clr),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .writeregM(writeregM),
    .writeregW(writeregW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memtoregM(memtoregM),
    .validW(validW), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  hazard_ctrl_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
    .regwriteD(regwriteD), .memtoregD(memtoregD), .validD(validD),
    .stallD(stallD), .flushE(flushE), .cnt_clr(cnt_clr),
    .rsE(rsE2), .rtE(rtE2), .writeregE(writeregE2), .writeregM(writeregM2),
    .writeregW(writeregW2), .regwriteE(regwriteE2), .regwriteM(regwriteM2),
    .regwriteW(regwriteW2), .memtoregE(memtoregE2), .memtoregM(memtoregM2),
    .validW(validW2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2),
    .retire_cnt(retire_cnt2)
  );

  // Reference model: an instruction slot per stage plus integer counters.
  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       rw, mt, v;
  } slot_t;

  slot_t ms_e, ms_m, ms_w;
  int    mc_stall, mc_flush, mc_retire;
  int    mc2_stall, mc2_flush, mc2_retire;

  function automatic slot_t empty_slot();
    slot_t s;
    s.rs = 0; s.rt = 0; s.wr = 0; s.rw = 0; s.mt = 0; s.v = 0;
    return s;
  endfunction

  function automatic int bump(int c, bit ev, int maxv);
    return (ev && c < maxv) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    ms_e = empty_slot(); ms_m = empty_slot(); ms_w = empty_slot();
    mc_stall = 0; mc_flush = 0; mc_retire = 0;
    mc2_stall = 0; mc2_flush = 0; mc2_retire = 0;
  endtask

  // Applies one clock edge to the model using the inputs held during the cycle.
  task automatic model_edge(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] wr, input logic rw, input logic mt,
                            input logic v, input logic st, input logic fl, input logic clr);
    slot_t n;
    bit retired;
    if (r) begin
      model_reset();
      return;
    end
    retired = ms_w.v;
    if (clr) begin
      mc_stall = 0; mc_flush = 0; mc_retire = 0;
      mc2_stall = 0; mc2_flush = 0; mc2_retire = 0;
    end else begin
      mc_stall   = bump(mc_stall, st, 65535);
      mc_flush   = bump(mc_flush, fl && !st, 65535);
      mc_retire  = bump(mc_retire, retired, 65535);
      mc2_stall  = bump(mc2_stall, st, 3);
      mc2_flush  = bump(mc2_flush, fl && !st, 3);
      mc2_retire = bump(mc2_retire, retired, 3);
    end
    n = empty_slot();
    if (v && !fl) begin
      n.rs = rs; n.rt = rt; n.wr = wr; n.mt = mt; n.v = 1;
      n.rw = rw && (wr != 0);
    end
    ms_w = ms_m;
    ms_m = ms_e;
    ms_e = n;
  endtask

  function automatic logic [84:0] dut_vec();
    return {rsE, rtE, writeregE, writeregM, writeregW, regwriteE, regwriteM,
            regwriteW, memtoregE, memtoregM, validW, stall_cnt, flush_cnt,
            retire_cnt, stall_cnt2, flush_cnt2, retire_cnt2};
  endfunction

  function automatic logic [84:0] mdl_vec();
    return {ms_e.rs, ms_e.rt, ms_e.wr, ms_m.wr, ms_w.wr, ms_e.rw, ms_m.rw,
            ms_w.rw, ms_e.mt, ms_m.mt, ms_w.v, 16'(mc_stall), 16'(mc_flush),
            16'(mc_retire), 2'(mc2_stall), 2'(mc2_flush), 2'(mc2_retire)};
  endfunction

  task automatic tick();
    logic r, rw, mt, v, st, fl, clr;
    logic [4:0] rs, rt, wr;
    r = reset; rs = rsD; rt = rtD; wr = writeregD; rw = regwriteD;
    mt = memtoregD; v = validD; st = stallD; fl = flushE; clr = cnt_clr;
    @(posedge clk);
    #1;
    model_edge(r, rs, rt, wr, rw, mt, v, st, fl, clr);
  endtask

  task automatic idle_inputs();
    reset = 0; rsD = 0; rtD = 0; writeregD = 0; regwriteD = 0; memtoregD = 0;
    validD = 0; stallD = 0; flushE = 0; cnt_clr = 0;
  endtask

  task automatic random_inputs();
    rsD = 5'($urandom); rtD = 5'($urandom); writeregD = 5'($urandom);
    regwriteD = 1'($urandom); memtoregD = 1'($urandom); validD = 1'($urandom);
    stallD = 1'($urandom); flushE = 1'($urandom); cnt_clr = 1'($urandom);
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 2; i++) begin
      random_inputs();
      reset = 1;
      tick();
      ncmp++;
      if (dut_vec() !== 85'd0) begin
        nfail++;
        $display("FAIL reset_zero: got %h want 0", dut_vec());
      end
      ncmp++;
      if (validW !== 1'b0 || validW2 !== 1'b0) begin
        nfail++;
        $display("FAIL reset_validW: got %b/%b want 0", validW, validW2);
      end
    end
    idle_inputs();
  endtask

  task automatic test_straight_flow();
    idle_inputs();
    validD = 1; rsD = 3; rtD = 4; writeregD = 7; regwriteD = 1; memtoregD = 1;
    tick();
    ncmp++;
    if ({rsE, rtE, writeregE, regwriteE, memtoregE} !== {5'd3, 5'd4, 5'd7, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL straight_E: got rs=%0d rt=%0d wr=%0d rw=%b mt=%b want 3 4 7 1 1",
               rsE, rtE, writeregE, regwriteE, memtoregE);
    end
    idle_inputs();
    tick();
    ncmp++;
    if ({writeregM, memtoregM} !== {5'd7, 1'b1}) begin
      nfail++;
      $display("FAIL straight_M: got wr=%0d mt=%b want 7 1", writeregM, memtoregM);
    end
    tick();
    ncmp++;
    if ({writeregW, regwriteW, validW} !== {5'd7, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL straight_W: got wr=%0d rw=%b v=%b want 7 1 1", writeregW, regwriteW, validW);
    end
    tick();
    ncmp++;
    if (retire_cnt !== 16'd1) begin
      nfail++;
      $display("FAIL straight_retire: got %0d want 1", retire_cnt);
    end
    ncmp++;
    if (dut_vec() !== mdl_vec()) begin
      nfail++;
      $display("FAIL straight_model: got %h want %h", dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_zero_gating();
    logic [2:0] seen;
    idle_inputs();
    validD = 1; writeregD = 0; regwriteD = 1; rsD = 9;
    tick();
    seen[0] = regwriteE;
    idle_inputs();
    tick();
    seen[1] = regwriteM;
    tick();
    seen[2] = regwriteW;
    ncmp++;
    if (seen !== 3'b000) begin
      nfail++;
      $display("FAIL zero_gating: got rwE/M/W=%b want 000", seen);
    end
    ncmp++;
    if (validW !== 1'b1) begin
      nfail++;
      $display("FAIL zero_gating_valid: got %b want 1", validW);
    end
  endtask

  task automatic test_load_use_stall();
    logic [15:0] s0, f0;
    idle_inputs();
    tick();
    s0 = stall_cnt; f0 = flush_cnt;
    validD = 1; rsD = 7; rtD = 2; writeregD = 5; regwriteD = 1; memtoregD = 0;
    stallD = 1; flushE = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      ncmp++;
      if ({regwriteE, memtoregE, rsE} !== {1'b0, 1'b0, 5'd0}) begin
        nfail++;
        $display("FAIL stall_bubble[%0d]: got rw=%b mt=%b rs=%0d want 0 0 0",
                 i, regwriteE, memtoregE, rsE);
      end
    end
    stallD = 0; flushE = 0;
    tick();
    ncmp++;
    if (rsE !== 5'd7) begin
      nfail++;
      $display("FAIL stall_release: got rsE=%0d want 7", rsE);
    end
    ncmp++;
    if (stall_cnt !== s0 + 16'd2 || flush_cnt !== f0) begin
      nfail++;
      $display("FAIL stall_counts: got stall=%0d flush=%0d want %0d %0d",
               stall_cnt, flush_cnt, s0 + 16'd2, f0);
    end
    idle_inputs();
  endtask

  task automatic test_branch_flush();
    logic [15:0] f0;
    idle_inputs();
    f0 = flush_cnt;
    validD = 1; rsD = 12; writeregD = 13; regwriteD = 1; flushE = 1;
    tick();
    ncmp++;
    if ({rsE, writeregE, regwriteE} !== 11'd0 || flush_cnt !== f0 + 16'd1) begin
      nfail++;
      $display("FAIL branch_flush: got rs=%0d wr=%0d rw=%b flush=%0d want 0 0 0 %0d",
               rsE, writeregE, regwriteE, flush_cnt, f0 + 16'd1);
    end
    flushE = 0;
    tick();
    ncmp++;
    if (rsE !== 5'd12 || flush_cnt !== f0 + 16'd1) begin
      nfail++;
      $display("FAIL branch_after: got rs=%0d flush=%0d want 12 %0d", rsE, flush_cnt, f0 + 16'd1);
    end
    idle_inputs();
  endtask

  task automatic test_saturation_clear();
    idle_inputs();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    stallD = 1; flushE = 1;
    for (int i = 0; i < 5; i++) tick();
    ncmp++;
    if (stall_cnt2 !== 2'd3) begin
      nfail++;
      $display("FAIL sat_stall: got %0d want 3", stall_cnt2);
    end
    cnt_clr = 1;
    tick();
    ncmp++;
    if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL sat_clear: got %0d/%0d want 0/0", stall_cnt2, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      reset   = ($urandom_range(0, 59) == 0);
      cnt_clr = ($urandom_range(0, 29) == 0);
      stallD  = ($urandom_range(0, 3) == 0);
      flushE  = stallD ? 1'b1 : ($urandom_range(0, 5) == 0);
      validD  = ($urandom_range(0, 4) != 0);
      tick();
      ncmp++;
      if (dut_vec() !== mdl_vec()) begin
        nfail++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      validD = 1; rsD = 5'(i + 1); rtD = 5'(i + 2); writeregD = 5'(i + 10);
      regwriteD = 1; memtoregD = 1'(i);
      tick();
      ncmp++;
      if (dut_vec() !== mdl_vec()) begin
        nfail++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_straight_flow();
    test_zero_gating();
    test_load_use_stall();
    test_branch_flush();
    test_saturation_clear();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

Register-tracking pipeline for the pipelined MIPS core that produces the register-number and control inputs the hazard unit consumes. It carries each decoded instruction's source/destination registers and write/memory-to-register controls from D through E, M and W, and applies the hazard unit's `flushE` to the D→E register. It also keeps saturating counters for stall cycles, flush bubbles and retired instructions for performance debug.

## Interface
- `CNT_W`, default 16: width of each performance counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rsD`, `rtD`  in  5 each  source registers of the instruction in D.
- `writeregD`  in  5  destination register of the instruction in D.
- `regwriteD`  in  1  instruction in D writes the register file.
- `memtoregD`  in  1  instruction in D is a load.
- `validD`  in  1  D holds a real instruction (not a bubble).
- `stallD`  in  1  from the hazard unit: D is stalled this cycle.
- `flushE`  in  1  from the hazard unit: insert a bubble into E.
- `cnt_clr`  in  1  synchronous clear of all three counters.
- `rsE`, `rtE`  out  5 each  source registers in E.
- `writeregE`, `writeregM`, `writeregW`  out  5 each  destination register per stage.
- `regwriteE`, `regwriteM`, `regwriteW`  out  1 each  register-write enable per stage.
- `memtoregE`, `memtoregM`  out  1 each  load flag per stage.
- `validW`  out  1  W holds a real instruction.
- `stall_cnt`, `flush_cnt`, `retire_cnt`  out  `CNT_W` each  performance counters.

## Operation
**D→E register**
- Loads every cycle.
- When `flushE`=1, or `validD`=0, E is loaded with a bubble: all fields 0, including valid, `regwrite` and `memtoreg`.
- Otherwise E captures the D fields.
- `stallD` does not hold E. A stalled instruction is kept in D by the upstream D register; the hazard unit asserts `flushE` during the stall.
- Write gating: if `writeregD`=0, `regwriteE` is loaded as 0. Register $0 is never a forwarding source.

**E→M and M→W**
- Unconditional shifts every cycle, with no stall or flush.
- M captures `writereg`, `regwrite`, `memtoreg` and valid from E.
- W captures `writereg`, `regwrite` and valid from M.

**Counters** (each saturates at 2^`CNT_W`−1 and holds there)
- `stall_cnt` increments in each cycle where `stallD`=1.
- `flush_cnt` increments in each cycle where `flushE`=1 and `stallD`=0 (branch-squash bubbles only).
- `retire_cnt` increments in each cycle where `validW`=1.
- When `cnt_clr`=1, all counters load 0 on that edge. Clear wins over a same-cycle increment.

**Reset**
- Every output is 0 after the edge where `reset`=1, including all counters.
- `reset` overrides both `flushE` and `cnt_clr`.
- Reset in mid-operation discards all in-flight stages on that edge.

## Timing
- Latency: D fields appear on the E outputs 1 cycle later, on M 2 cycles later, on W 3 cycles later.
- All outputs are registered. There is no combinational path from any input to any output, so there is no loop with the combinational hazard unit.
- A `flushE` pulse produces exactly one bubble, visible in E for 1 cycle, then in M, then in W.
- A stall of N cycles with `flushE` held high produces N consecutive bubbles and adds N to `stall_cnt`. `flush_cnt` is unchanged.
- Counters update on the same edge as the event cycle; the new value is visible the following cycle.

## Test plan
1. **Reset.** Drive arbitrary inputs with `reset`=1 for 2 cycles. All outputs must read 0, and `validW` must be 0.
2. **Straight flow.** After reset, drive `validD`=1, `rsD`=3, `rtD`=4, `writeregD`=7, `regwriteD`=1, `memtoregD`=1.
   - Cycle+1: `rsE`=3, `rtE`=4, `writeregE`=7, `regwriteE`=1, `memtoregE`=1.
   - Cycle+2: `writeregM`=7 with `memtoregM`=1.
   - Cycle+3: `writeregW`=7, `regwriteW`=1, `validW`=1.
   - `retire_cnt`=1 on the following cycle.
3. **$0 gating.** Drive `writeregD`=0 with `regwriteD`=1. `regwriteE`, `regwriteM` and `regwriteW` must be 0 in succession.
4. **Load-use stall.** Hold `stallD`=1 and `flushE`=1 for 2 cycles while D holds `rsD`=7.
   - E must show bubbles (`regwriteE`=0, `memtoregE`=0) for 2 cycles.
   - `stall_cnt` increases by 2; `flush_cnt` does not change.
   - After the stall is released, the `rsD`=7 instruction reaches E.
5. **Branch flush.** One cycle with `flushE`=1 and `stallD`=0. This gives one bubble in E, and `flush_cnt` increases by 1.
6. **Saturation and clear.** With `CNT_W`=2, hold `stallD`=1 for 5 cycles; `stall_cnt` must stop at 3. Then assert `cnt_clr`=1 together with `stallD`=1; `stall_cnt` must read 0 on the next cycle.
